xoodoo_perm_ctrl: RTL



---
 rtl/xoodoo_perm_ctrl_if.sv | 31 +++
 rtl/xoodoo_perm_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/xoodoo_perm_ctrl_if.sv
// Handshake bundle between the Xoodyak datapath and the permutation engine.
// The datapath side uses master; the engine uses slave.
interface xoodoo_perm_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [383:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [383:0] state_out;
    logic         busy;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out,
        output busy
    );
endinterface

// File: rtl/xoodoo_perm_ctrl.sv
// Iterative Xoodoo[n] permutation engine: one state register, RPC
// unrolled rounds per clock, valid/ready on both input and output.

// One Xoodoo round (theta, rho-west, iota, chi, rho-east).
// Lane (x,y) sits at bits [128*y+32*x +: 32].
module xoodoo_round (
    input  logic [383:0] s_i,
    input  logic [31:0]  rc_i,
    output logic [383:0] s_o
);
    function automatic logic [31:0] rotl(
        input logic [31:0] v,
        input int          n
    );
        return (v << n) | (v >> (32 - n));
    endfunction

    logic [3:0][31:0] a0, a1, a2;
    logic [3:0][31:0] p, e;
    logic [3:0][31:0] t0, t1, t2;
    logic [3:0][31:0] c0, c1, c2;

    for (genvar x = 0; x < 4; x++) begin : g_col
        localparam int XM1 = (x + 3) % 4;
        localparam int XM2 = (x + 2) % 4;

        assign a0[x] = s_i[32*x +: 32];
        assign a1[x] = s_i[128 + 32*x +: 32];
        assign a2[x] = s_i[256 + 32*x +: 32];

        // Column parity and theta effect from the neighbour column.
        assign p[x] = a0[x] ^ a1[x] ^ a2[x];
        assign e[x] = rotl(p[XM1], 5) ^ rotl(p[XM1], 14);

        // theta + rho-west, iota folded into lane (0,0).
        assign t0[x] = a0[x] ^ e[x] ^ ((x == 0) ? rc_i : 32'h0);
        assign t1[x] = a1[XM1] ^ e[XM1];
        assign t2[x] = rotl(a2[x] ^ e[x], 11);

        // chi across the three planes.
        assign c0[x] = t0[x] ^ (~t1[x] & t2[x]);
        assign c1[x] = t1[x] ^ (~t2[x] & t0[x]);
        assign c2[x] = t2[x] ^ (~t0[x] & t1[x]);

        // rho-east.
        assign s_o[32*x +: 32]       = c0[x];
        assign s_o[128 + 32*x +: 32] = rotl(c1[x], 1);
        assign s_o[256 + 32*x +: 32] = rotl(c2[XM2], 8);
    end
endmodule

module xoodoo_perm_ctrl #(
    parameter int ROUNDS = 12,
    parameter int RPC    = 1
) (
    input logic               clk,
    input logic               rst,
    xoodoo_perm_ctrl_if.slave bus
);
    localparam int N      = ROUNDS / RPC;
    localparam int CW     = $clog2(N + 1);
    localparam int RC_OFS = 12 - ROUNDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Round-constant ROM for the full 12-round schedule.
    function automatic logic [31:0] rc_rom(input int idx);
        logic [31:0] rc;
        case (idx)
            0:       rc = 32'h0000_0058;
            1:       rc = 32'h0000_0038;
            2:       rc = 32'h0000_03C0;
            3:       rc = 32'h0000_00D0;
            4:       rc = 32'h0000_0120;
            5:       rc = 32'h0000_0014;
            6:       rc = 32'h0000_0060;
            7:       rc = 32'h0000_002C;
            8:       rc = 32'h0000_0380;
            9:       rc = 32'h0000_00F0;
            10:      rc = 32'h0000_01A0;
            11:      rc = 32'h0000_0012;
            default: rc = 32'h0000_0000;
        endcase
        return rc;
    endfunction

    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [383:0]  s_q, s_d;

    logic [RPC:0][383:0] chain;
    logic [RPC-1:0][31:0] rc;

    assign chain[0] = s_q;

    // Unrolled round chain; stage k runs schedule index cnt*RPC+k.
    for (genvar k = 0; k < RPC; k++) begin : g_rnd
        assign rc[k] = rc_rom(RC_OFS + int'(cnt_q) * RPC + k);

        xoodoo_round u_round (
            .s_i  (chain[k]),
            .rc_i (rc[k]),
            .s_o  (chain[k+1])
        );
    end

    // Outputs decode the state register only, so no input feeds through.
    assign bus.in_ready  = (st_q == IDLE);
    assign bus.out_valid = (st_q == DONE);
    assign bus.busy      = (st_q != IDLE);
    assign bus.state_out = s_q;

    // Next-state logic: load in IDLE, iterate in RUN, hold in DONE.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        s_d   = s_q;
        unique case (st_q)
            IDLE: begin
                if (bus.in_valid) begin
                    s_d   = bus.state_in;
                    cnt_d = '0;
                    st_d  = RUN;
                end
            end
            RUN: begin
                s_d   = chain[RPC];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    st_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that discards any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            s_q   <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            s_q   <= s_d;
        end
    end
endmodule
